// File: rtl/ybuf_rd_pkg.sv
// Shared types and constants for the classifier output-buffer reader.
package ybuf_rd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StOut,
    StDone
  } state_e;

  localparam int unsigned ADDR_STRIDE = 4;
  localparam int unsigned CLASS_IDX_W = 4;

endpackage

// File: rtl/argmax_seq.sv
// Sequential signed argmax over a stream of scores; ties keep the earliest index.
// Exposes the running max as max_o only when YBUF_RD_SCORE_OUT_EN is defined.
module argmax_seq
  import ybuf_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [DATA_WIDTH-1:0]  score_i,
`ifdef YBUF_RD_SCORE_OUT_EN
  output logic [DATA_WIDTH-1:0]  max_o,
`endif
  output logic [CLASS_IDX_W-1:0] idx_o
);

  logic                   first_q;
  logic [CLASS_IDX_W-1:0] cnt_q;
  logic [DATA_WIDTH-1:0]  max_q;
  logic [CLASS_IDX_W-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q <= 1'b1;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else if (valid_i) begin
      first_q <= 1'b0;
      cnt_q   <= cnt_q + 1'b1;
      // First score loads unconditionally; later ones only on strict signed win.
      if (first_q || ($signed(score_i) > $signed(max_q))) begin
        max_q <= score_i;
        idx_q <= cnt_q;
      end
    end
  end

`ifdef YBUF_RD_SCORE_OUT_EN
  assign max_o = max_q;
`endif
  assign idx_o = idx_q;

endmodule

// File: rtl/y_buf_reader.sv
// Drains the classifier output buffer image by image and streams one argmax class per image.
// Optional score_o output of the winning score is enabled by YBUF_RD_SCORE_OUT_EN.
module y_buf_reader
  import ybuf_rd_pkg::*;
#(
  parameter int unsigned IN_IMG_NUM = 10,
  parameter int unsigned CLASS_NUM  = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  output logic                          buf_en_o,
  output logic [ADDR_WIDTH-1:0]         buf_addr_o,
  input  logic [DATA_WIDTH-1:0]         buf_data_i,
  output logic                          class_valid_o,
  input  logic                          class_ready_i,
  output logic [3:0]                    class_o,
  output logic [$clog2(IN_IMG_NUM)-1:0] img_idx_o,
`ifdef YBUF_RD_SCORE_OUT_EN
  output logic [DATA_WIDTH-1:0]         score_o,
`endif
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned ImgW = $clog2(IN_IMG_NUM);
  localparam logic [ImgW-1:0]        LastImg = ImgW'(IN_IMG_NUM - 1);
  localparam logic [CLASS_IDX_W-1:0] LastK   = CLASS_IDX_W'(CLASS_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0]  Stride  = ADDR_WIDTH'(ADDR_STRIDE);

  state_e                 state_q;
  logic [ImgW-1:0]        img_q;
  logic [CLASS_IDX_W-1:0] k_q;
  logic                   en_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   rd_vld_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   arg_clear;

  // Argmax restarts at the beginning of every image's read burst.
  assign arg_clear = ((state_q == StIdle) && start_i) ||
                     ((state_q == StOut) && class_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      img_q    <= '0;
      k_q      <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_vld_q <= en_q;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StRead;
            img_q   <= '0;
            k_q     <= '0;
            en_q    <= 1'b1;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRead: begin
          if (k_q == LastK) begin
            state_q <= StDrain;
            en_q    <= 1'b0;
          end else begin
            k_q    <= k_q + 1'b1;
            addr_q <= addr_q + Stride;
          end
        end
        StDrain: begin
          state_q <= StOut;
          valid_q <= 1'b1;
        end
        StOut: begin
          if (class_ready_i) begin
            valid_q <= 1'b0;
            if (img_q == LastImg) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // Images are packed back to back, so the next burst continues linearly.
              state_q <= StRead;
              img_q   <= img_q + 1'b1;
              k_q     <= '0;
              en_q    <= 1'b1;
              addr_q  <= addr_q + Stride;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [CLASS_IDX_W-1:0] arg_idx;

  argmax_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_argmax (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(arg_clear),
    .valid_i(rd_vld_q),
    .score_i(buf_data_i),
`ifdef YBUF_RD_SCORE_OUT_EN
    .max_o  (score_o),
`endif
    .idx_o  (arg_idx)
  );

  assign buf_en_o      = en_q;
  assign buf_addr_o    = addr_q;
  assign class_valid_o = valid_q;
  assign class_o       = arg_idx;
  assign img_idx_o     = img_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_y_buf_reader.sv
// Randomized bench for y_buf_reader against a behavioural buffer and argmax model.
// Score output checks are compiled in when YBUF_RD_SCORE_OUT_EN is defined.
module tb_y_buf_reader;

  localparam int ImgN = 10;
  localparam int ClsN = 10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        buf_en_o;
  logic [31:0] buf_addr_o;
  logic [31:0] buf_data_i;
  logic        class_valid_o;
  logic        class_ready_i;
  logic [3:0]  class_o;
  logic [3:0]  img_idx_o;
  logic        busy_o;
  logic        done_o;
`ifdef YBUF_RD_SCORE_OUT_EN
  logic [31:0] score_o;
`endif

  always #5 clk = ~clk;

  y_buf_reader #(
    .IN_IMG_NUM(ImgN),
    .CLASS_NUM (ClsN),
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .buf_en_o     (buf_en_o),
    .buf_addr_o   (buf_addr_o),
    .buf_data_i   (buf_data_i),
    .class_valid_o(class_valid_o),
    .class_ready_i(class_ready_i),
    .class_o      (class_o),
    .img_idx_o    (img_idx_o),
`ifdef YBUF_RD_SCORE_OUT_EN
    .score_o      (score_o),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  logic [31:0] mem [ImgN*ClsN];
  int          exp_cls [ImgN];
  logic [31:0] exp_score [ImgN];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Buffer returns the addressed word one cycle after the read enable.
  initial buf_data_i = '0;
  always @(posedge clk) begin
    if (buf_en_o) buf_data_i <= mem[buf_addr_o[8:2]];
  end

  function automatic void build_model();
    for (int i = 0; i < ImgN; i++) begin
      logic signed [31:0] best;
      int bi;
      best = $signed(mem[i*ClsN]);
      bi   = 0;
      for (int k = 1; k < ClsN; k++) begin
        if ($signed(mem[i*ClsN+k]) > best) begin
          best = $signed(mem[i*ClsN+k]);
          bi   = k;
        end
      end
      exp_cls[i]   = bi;
      exp_score[i] = best;
    end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < ImgN*ClsN; i++) mem[i] = 32'($urandom_range(0, 15)) - 32'd8;
  endfunction

  int          exp_addr = 0;
  int          res_cnt  = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  bit          prev_hold = 1'b0;
  logic [3:0]  prev_cls, prev_img;

  always @(negedge clk) begin
    if (mon_en) begin
      if (buf_en_o) begin
        check_eq("rd_addr", buf_addr_o, exp_addr);
        exp_addr += 4;
      end
      if (done_o) done_cnt++;
      if (class_valid_o) begin
        check_eq("no_rd_while_valid", {31'd0, buf_en_o}, 32'd0);
        if (prev_hold) begin
          check_eq("hold_cls", class_o, prev_cls);
          check_eq("hold_img", img_idx_o, prev_img);
        end
        if (class_ready_i) begin
          check_eq("res_img", img_idx_o, res_cnt);
          if (res_cnt < ImgN) begin
            check_eq("res_cls", class_o, exp_cls[res_cnt]);
`ifdef YBUF_RD_SCORE_OUT_EN
            check_eq("res_score", score_o, exp_score[res_cnt]);
`endif
          end else begin
            check_eq("res_overflow", res_cnt, ImgN - 1);
          end
          res_cnt++;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_cls  = class_o;
          prev_img  = img_idx_o;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_en"},    {31'd0, buf_en_o}, 32'd0);
    check_eq({tag, "_addr"},  buf_addr_o, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, class_valid_o}, 32'd0);
    check_eq({tag, "_cls"},   class_o, 32'd0);
    check_eq({tag, "_img"},   img_idx_o, 32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
    check_eq({tag, "_done"},  {31'd0, done_o}, 32'd0);
`ifdef YBUF_RD_SCORE_OUT_EN
    check_eq({tag, "_score"}, score_o, 32'd0);
`endif
  endtask

  // One full sequence; optional stall, stray start pulse, or mid-run reset by image number.
  task automatic run_seq(input int stall_img, input int pulse_img, input int rst_img);
    int cycles, stall_cnt, first_v;
    bit pulsed, aborted;
    build_model();
    exp_addr  = 0;
    res_cnt   = 0;
    done_cnt  = 0;
    prev_hold = 1'b0;
    mon_en    = 1'b1;
    cycles    = 0;
    stall_cnt = 0;
    first_v   = -1;
    pulsed    = 1'b0;
    aborted   = 1'b0;
    @(posedge clk); #1;
    start_i       = 1'b1;
    class_ready_i = 1'b1;
    while (done_cnt == 0 && cycles < 2000 && !aborted) begin
      @(posedge clk); #1;
      cycles++;
      start_i = 1'b0;
      if (class_valid_o && first_v < 0) first_v = cycles;
      if (class_valid_o && img_idx_o == stall_img && stall_cnt < 20) begin
        class_ready_i = 1'b0;
        stall_cnt++;
      end else begin
        class_ready_i = 1'b1;
      end
      if (!pulsed && buf_en_o && img_idx_o == pulse_img) begin
        start_i = 1'b1;
        pulsed  = 1'b1;
      end
      if (buf_en_o && img_idx_o == rst_img) begin
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i   = 1'b0;
        aborted = 1'b1;
        check_reset_outs("abort_rst");
      end
    end
    check_eq("first_valid_cycle", first_v, 12);
    if (!aborted) begin
      check_eq("no_timeout", {31'd0, cycles < 2000}, 32'd1);
      check_eq("busy_after_done", {31'd0, busy_o}, 32'd0);
      check_eq("res_count", res_cnt, ImgN);
      check_eq("rd_count", exp_addr, ImgN*ClsN*4);
      if (stall_img < ImgN) check_eq("stall_cycles", stall_cnt, 20);
      repeat (3) @(posedge clk);
      #1;
      check_eq("done_pulses", done_cnt, 1);
    end
    mon_en = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    start_i       = 1'b0;
    class_ready_i = 1'b0;
    fill_random();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_outs("por");

    // Fixed image 0 with a tie between indices 2 and 4.
    begin
      int s0 [ClsN] = '{5, -3, 7, 2, 7, 1, 0, -8, 6, 4};
      for (int k = 0; k < ClsN; k++) mem[k] = s0[k];
    end
    run_seq(99, 99, 99);

    // All negative, maximum in the last slot of every image.
    for (int i = 0; i < ImgN*ClsN; i++) mem[i] = (i % ClsN == ClsN - 1) ? -32'sd1 : -32'sd100;
    run_seq(99, 99, 99);

    fill_random();
    run_seq(3, 99, 99);

    fill_random();
    run_seq(99, 1, 99);

    fill_random();
    run_seq(99, 99, 5);
    fill_random();
    run_seq(99, 99, 99);

    // Extreme positive score at k=4 of image 0.
    fill_random();
    mem[4] = 32'h7FFF_FFFF;
    run_seq(99, 99, 99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
